load_store_unit: RTL and testbench

Data-side initiator that sits between the CPU's memory stage and the word-addressed synchronous data memory. It accepts byte, halfword and word loads and stores at byte addresses, and issues the matching memory commands on the memory's `rw`/`ain`/`din`/`dout` port. Sub-word stores are performed as read-modify-write. Alignment and range errors are reported back to the pipeline without touching memory.

---
 rtl/load_store_unit.sv | 172 +++++++++++++++++
 tb/tb_load_store_unit.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word CPU accesses at byte addresses into
// commands for a word-addressed synchronous data memory. Sub-word stores are
// done as read-modify-write; bad requests are answered without a memory access.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | ready; accept and check a request
// S_READ  | word address presented with mem_rw = 0, memory samples it
// S_WAIT  | mem_dout valid: extract load lane or merge store lane
// S_WRITE | mem_rw = 1, memory writes at the exiting edge
// S_DONE  | resp_valid pulse for one cycle
module load_store_unit #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [31:0] resp_rdata,
  output logic        mem_rw,
  output logic [31:0] mem_ain,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;
  logic        r_mem_rw;
  logic [31:0] r_mem_ain;
  logic [31:0] r_mem_din;
  logic        r_resp_valid;
  logic        r_resp_error;
  logic [31:0] r_resp_rdata;

  logic        w_err;
  logic        w_word_store;
  logic [4:0]  w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_lane_mask;
  logic [31:0] w_ins;
  logic [31:0] w_merged;

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_error = r_resp_error;
  assign resp_rdata = r_resp_rdata;
  assign mem_rw     = r_mem_rw;
  assign mem_ain    = r_mem_ain;
  assign mem_din    = r_mem_din;

  // Request legality and the word-store shortcut, decoded from the live inputs.
  always_comb begin
    w_err = (req_size == 2'b11)
         || (req_size == 2'b01 && req_addr[0])
         || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
         || ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
    w_word_store = req_we && (req_size == 2'b10);
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    w_shift     = {r_lane, 3'b000};
    w_byte      = 8'(mem_dout >> w_shift);
    w_half      = 16'(mem_dout >> w_shift);
    w_load      = mem_dout;
    w_lane_mask = 32'h0;
    w_ins       = 32'h0;
    case (r_size)
      2'b00: begin
        w_load      = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
        w_lane_mask = 32'h0000_00FF << w_shift;
        w_ins       = {24'h0, r_wdata[7:0]} << w_shift;
      end
      2'b01: begin
        w_load      = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
        w_lane_mask = 32'h0000_FFFF << w_shift;
        w_ins       = {16'h0, r_wdata} << w_shift;
      end
      default: ;
    endcase
    w_merged = (mem_dout & ~w_lane_mask) | w_ins;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_err)             w_next = S_DONE;
          else if (w_word_store) w_next = S_WRITE;
          else                   w_next = S_READ;
        end
      end
      S_READ:  w_next = S_WAIT;
      S_WAIT:  w_next = r_we ? S_WRITE : S_DONE;
      S_WRITE: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Request latch and registered memory/response outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_lane       <= 2'b00;
      r_wdata      <= 16'h0;
      r_mem_rw     <= 1'b0;
      r_mem_ain    <= 32'h0;
      r_mem_din    <= 32'h0;
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_resp_rdata <= 32'h0;
    end else begin
      r_mem_rw     <= (w_next == S_WRITE);
      r_resp_valid <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we         <= req_we;
            r_size       <= req_size;
            r_unsigned   <= req_unsigned;
            r_lane       <= req_addr[1:0];
            r_wdata      <= req_wdata[15:0];
            r_resp_error <= w_err;
            r_resp_rdata <= 32'h0;
            if (!w_err) r_mem_ain <= {2'b00, req_addr[31:2]};
            if (!w_err && w_word_store) r_mem_din <= req_wdata;
          end
        end
        S_WAIT: begin
          if (r_we) r_mem_din    <= w_merged;
          else      r_resp_rdata <= w_load;
        end
        S_DONE: begin
          r_resp_error <= 1'b0;
          r_resp_rdata <= 32'h0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a synchronous word memory stand-in plus a
// byte-oriented reference model of what loads and stores should do.
module tb_load_store_unit;

  localparam int MEM_WORDS = 1024;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] resp_rdata;
  logic        mem_rw;
  logic [31:0] mem_ain;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem     [0:MEM_WORDS-1];
  logic [31:0] ref_mem [0:MEM_WORDS-1];
  logic        mem_clear;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_error(resp_error),
    .resp_rdata(resp_rdata), .mem_rw(mem_rw), .mem_ain(mem_ain),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clock = ~clock;

  // Synchronous data memory with registered read port.
  always @(posedge clock) begin
    if (mem_clear) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'h0;
    end else if (mem_rw) begin
      mem[mem_ain[9:0]] <= mem_din;
    end
    mem_dout <= mem[mem_ain[9:0]];
  end

  function automatic logic model_err(logic [1:0] size, logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
           (size == 2'd2 && addr % 4 != 0) || (addr / 4 >= MEM_WORDS);
  endfunction

  function automatic int model_lat(logic we, logic [1:0] size, logic [31:0] addr);
    if (model_err(size, addr)) return 1;
    if (!we) return 3;
    if (size == 2'd2) return 2;
    return 4;
  endfunction

  function automatic int nbytes(logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(logic [1:0] size, logic uns, logic [31:0] addr);
    logic [31:0] v;
    logic [31:0] a;
    int n;
    n = nbytes(size);
    v = 32'h0;
    for (int i = 0; i < n; i++) begin
      a = addr + i;
      v = v | (((ref_mem[a[11:2]] >> (8 * a[1:0])) & 32'hFF) << (8 * i));
    end
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata);
    logic [31:0] a;
    logic [31:0] w;
    for (int i = 0; i < nbytes(size); i++) begin
      a = addr + i;
      w = ref_mem[a[11:2]];
      w = (w & ~(32'hFF << (8 * a[1:0]))) | (((wdata >> (8 * i)) & 32'hFF) << (8 * a[1:0]));
      ref_mem[a[11:2]] = w;
    end
  endtask

  // Issue one request from an idle unit and observe it until its response.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic err, output logic [31:0] rdata,
                        output int rw_cnt, output int rw_at, output logic [31:0] ain,
                        output logic ready_at_issue, output logic resp_after);
    lat = 0; err = 1'bx; rdata = 'x; rw_cnt = 0; rw_at = 0; ain = 'x;
    @(negedge clock);
    ready_at_issue = req_ready;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0; req_we = $urandom_range(0, 1); req_size = $urandom_range(0, 3);
    req_unsigned = $urandom_range(0, 1); req_addr = $urandom; req_wdata = $urandom;
    for (int n = 1; n <= 20; n++) begin
      if (mem_rw) begin rw_cnt++; rw_at = n; end
      if (resp_valid) begin
        lat = n; err = resp_error; rdata = resp_rdata; ain = mem_ain;
        break;
      end
      @(negedge clock);
    end
    @(negedge clock);
    resp_after = resp_valid;
  endtask

  int          lat, rw_cnt, rw_at;
  logic        err, rdy, after;
  logic [31:0] rdata, ain;

  task automatic test_reset;
    checks++;
    if ({mem_rw, resp_valid, resp_error, req_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_ctl got %b exp 0001", {mem_rw, resp_valid, resp_error, req_ready});
    end
    checks++;
    if ({mem_ain, mem_din, resp_rdata} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data got %h exp 0", {mem_ain, mem_din, resp_rdata});
    end
    mem_clear = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({mem_rw, resp_valid, resp_error, req_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL post_reset_ctl got %b exp 0001", {mem_rw, resp_valid, resp_error, req_ready});
    end
    checks++;
    if ({mem_ain, mem_din, resp_rdata} !== 96'h0) begin
      errors++;
      $display("FAIL post_reset_data got %h exp 0", {mem_ain, mem_din, resp_rdata});
    end
  endtask

  task automatic test_word_store_load;
    do_req(1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF, lat, err, rdata, rw_cnt, rw_at, ain, rdy, after);
    model_store(2'd2, 32'h10, 32'hDEAD_BEEF);
    checks++;
    if (lat !== 2 || err !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL wstore got lat=%0d err=%b rdata=%h exp lat=2 err=0 rdata=0", lat, err, rdata);
    end
    checks++;
    if (rw_cnt !== 1 || rw_at !== 1 || after !== 1'b0) begin
      errors++;
      $display("FAIL wstore_rw got cnt=%0d at=%0d after=%b exp cnt=1 at=1 after=0", rw_cnt, rw_at, after);
    end
    do_req(0, 2'd2, 0, 32'h10, 32'h0, lat, err, rdata, rw_cnt, rw_at, ain, rdy, after);
    checks++;
    if (lat !== 3 || err !== 1'b0 || rdata !== 32'hDEAD_BEEF || ain !== 32'd4 || rw_cnt !== 0) begin
      errors++;
      $display("FAIL wload got lat=%0d err=%b rdata=%h ain=%h rw=%0d exp 3 0 deadbeef 4 0",
               lat, err, rdata, ain, rw_cnt);
    end
  endtask

  task automatic test_byte_merge;
    do_req(1, 2'd2, 0, 32'h20, 32'h1122_3344, lat, err, rdata, rw_cnt, rw_at, ain, rdy, after);
    model_store(2'd2, 32'h20, 32'h1122_3344);
    do_req(1, 2'd0, 0, 32'h23, 32'h5A5A_5AAA, lat, err, rdata, rw_cnt, rw_at, ain, rdy, after);
    model_store(2'd0, 32'h23, 32'h5A5A_5AAA);
    checks++;
    if (lat !== 4 || err !== 1'b0 || rw_cnt !== 1 || rw_at !== 3) begin
      errors++;
      $display("FAIL bstore got lat=%0d err=%b rw_cnt=%0d rw_at=%0d exp 4 0 1 3", lat, err, rw_cnt, rw_at);
    end
    do_req(0, 2'd2, 0, 32'h20, 32'h0, lat, err, rdata, rw_cnt, rw_at, ain, rdy, after);
    checks++;
    if (rdata !== 32'hAA22_3344 || err !== 1'b0) begin
      errors++;
      $display("FAIL bmerge got %h exp aa223344", rdata);
    end
  endtask

  task automatic test_extension;
    logic [1:0]  sz [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
    logic        un [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ad [5] = '{32'h0, 32'h0, 32'h0, 32'h2, 32'h1};
    logic [31:0] ex [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8080, 32'h0, 32'hFFFF_FF80};
    do_req(1, 2'd2, 0, 32'h0, 32'h0000_8080, lat, err, rdata, rw_cnt, rw_at, ain, rdy, after);
    model_store(2'd2, 32'h0, 32'h0000_8080);
    for (int i = 0; i < 5; i++) begin
      do_req(0, sz[i], un[i], ad[i], 32'h0, lat, err, rdata, rw_cnt, rw_at, ain, rdy, after);
      checks++;
      if (rdata !== ex[i] || lat !== 3 || err !== 1'b0) begin
        errors++;
        $display("FAIL ext_%0d got rdata=%h lat=%0d err=%b exp %h 3 0", i, rdata, lat, err, ex[i]);
      end
    end
  endtask

  task automatic test_errors;
    do_req(0, 2'd1, 0, 32'h1, 32'h0, lat, err, rdata, rw_cnt, rw_at, ain, rdy, after);
    checks++;
    if (err !== 1'b1 || lat !== 1 || rdata !== 32'h0 || rw_cnt !== 0) begin
      errors++;
      $display("FAIL err_half got err=%b lat=%0d rdata=%h rw=%0d exp 1 1 0 0", err, lat, rdata, rw_cnt);
    end
    do_req(1, 2'd2, 0, 32'h1000, 32'h1234_5678, lat, err, rdata, rw_cnt, rw_at, ain, rdy, after);
    checks++;
    if (err !== 1'b1 || lat !== 1 || rw_cnt !== 0 || mem[0] !== 32'h0000_8080) begin
      errors++;
      $display("FAIL err_range got err=%b lat=%0d rw=%0d mem0=%h exp 1 1 0 00008080", err, lat, rw_cnt, mem[0]);
    end
    do_req(0, 2'd3, 0, 32'h4, 32'h0, lat, err, rdata, rw_cnt, rw_at, ain, rdy, after);
    checks++;
    if (err !== 1'b1 || lat !== 1 || rw_cnt !== 0) begin
      errors++;
      $display("FAIL err_size got err=%b lat=%0d rw=%0d exp 1 1 0", err, lat, rw_cnt);
    end
    do_req(0, 2'd2, 0, 32'hFFC, 32'h0, lat, err, rdata, rw_cnt, rw_at, ain, rdy, after);
    checks++;
    if (err !== 1'b0 || lat !== 3 || rdata !== model_load(2'd2, 0, 32'hFFC)) begin
      errors++;
      $display("FAIL last_word got err=%b lat=%0d rdata=%h exp 0 3 %h", err, lat, rdata,
               model_load(2'd2, 0, 32'hFFC));
    end
  endtask

  task automatic test_reset_in_write;
    logic saw;
    do_req(1, 2'd2, 0, 32'h8, 32'h77, lat, err, rdata, rw_cnt, rw_at, ain, rdy, after);
    model_store(2'd2, 32'h8, 32'h77);
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h8; req_wdata = 32'h55;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    checks++;
    if (mem_rw !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_rw got %b exp 1", mem_rw);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (mem_rw !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_async got rw=%b ready=%b exp 0 1", mem_rw, req_ready);
    end
    saw = 1'b0;
    repeat (2) begin @(negedge clock); if (resp_valid) saw = 1'b1; end
    reset = 1'b1;
    repeat (4) begin @(negedge clock); if (resp_valid) saw = 1'b1; end
    checks++;
    if (saw !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_resp got resp_valid seen exp none");
    end
    do_req(0, 2'd2, 0, 32'h8, 32'h0, lat, err, rdata, rw_cnt, rw_at, ain, rdy, after);
    checks++;
    if (rdata !== 32'h77 || err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mem got %h exp 00000077", rdata);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] q_rdata [$];
    int          q_lat   [$];
    int          q_acc   [$];
    int          acc, rsp, cyc, a_idx;
    logic        prev_acc;
    logic [31:0] last_addr, a;
    logic [1:0]  s;
    acc = 0; rsp = 0; cyc = 0; prev_acc = 1'b0; last_addr = 32'h200;
    @(negedge clock);
    while (rsp < 8 && cyc < 200) begin
      if (prev_acc) begin
        checks++;
        if (req_ready !== 1'b0) begin
          errors++;
          $display("FAIL hs_ready_busy got 1 exp 0 at cyc %0d", cyc);
        end
      end
      if (resp_valid) begin
        checks++;
        if (q_rdata.size() == 0 || resp_rdata !== q_rdata[0] || resp_error !== 1'b0 ||
            req_ready !== 1'b0 || cyc - q_acc[0] !== q_lat[0]) begin
          errors++;
          $display("FAIL hs_resp_%0d got rdata=%h err=%b ready=%b", rsp, resp_rdata, resp_error, req_ready);
        end
        if (q_rdata.size() != 0) begin
          void'(q_rdata.pop_front()); void'(q_lat.pop_front()); void'(q_acc.pop_front());
        end
        rsp++;
      end
      prev_acc = 1'b0;
      if (req_ready) begin
        if (acc < 8) begin
          if (acc % 2 == 0) begin
            s = ($urandom_range(0, 1) != 0) ? 2'd2 : 2'd0;
            a_idx = $urandom_range(0, 7);
            a = 32'h200 + 32'(4 * a_idx) + ((s == 2'd0) ? 32'($urandom_range(0, 3)) : 32'h0);
            req_we = 1'b1; req_size = s; req_unsigned = 1'b0; req_addr = a; req_wdata = $urandom;
            model_store(s, a, req_wdata);
            q_rdata.push_back(32'h0);
            q_lat.push_back(model_lat(1'b1, s, a));
            last_addr = a & 32'hFFFF_FFFC;
          end else begin
            req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = last_addr; req_wdata = $urandom;
            q_rdata.push_back(model_load(2'd2, 1'b0, last_addr));
            q_lat.push_back(3);
          end
          q_acc.push_back(cyc);
          req_valid = 1'b1;
          acc++;
          prev_acc = 1'b1;
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clock);
      cyc++;
    end
    req_valid = 1'b0;
    checks++;
    if (acc !== 8 || rsp !== 8) begin
      errors++;
      $display("FAIL hs_count got acc=%0d rsp=%0d exp 8 8", acc, rsp);
    end
    @(negedge clock);
  endtask

  task automatic test_random;
    logic        we, uns, e_err;
    logic [1:0]  size;
    logic [31:0] addr, wdata, e_rdata;
    int          r, e_lat, mism;
    for (int i = 0; i < 150; i++) begin
      we = $urandom_range(0, 1);
      uns = $urandom_range(0, 1);
      r = $urandom_range(0, 15);
      size = (r == 0) ? 2'd3 : 2'(r % 3);
      addr = 32'h100 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 1) != 0 && size != 2'd3) addr = addr & ~(32'(nbytes(size)) - 1);
      if ($urandom_range(0, 9) == 0) addr = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
      wdata = $urandom;
      e_err = model_err(size, addr);
      e_lat = model_lat(we, size, addr);
      e_rdata = (!we && !e_err) ? model_load(size, uns, addr) : 32'h0;
      do_req(we, size, uns, addr, wdata, lat, err, rdata, rw_cnt, rw_at, ain, rdy, after);
      if (we && !e_err) model_store(size, addr, wdata);
      checks++;
      if (err !== e_err || lat !== e_lat || rdata !== e_rdata) begin
        errors++;
        $display("FAIL rand_%0d we=%b sz=%0d a=%h got err=%b lat=%0d rdata=%h exp %b %0d %h",
                 i, we, size, addr, err, lat, rdata, e_err, e_lat, e_rdata);
      end
      checks++;
      if (rw_cnt !== ((we && !e_err) ? 1 : 0) || rdy !== 1'b1 || after !== 1'b0) begin
        errors++;
        $display("FAIL rand_ctl_%0d got rw_cnt=%0d ready=%b after=%b", i, rw_cnt, rdy, after);
      end
    end
    mism = 0;
    for (int w = 0; w < MEM_WORDS; w++) if (mem[w] !== ref_mem[w]) mism++;
    checks++;
    if (mism !== 0) begin
      errors++;
      $display("FAIL mem_image got %0d differing words exp 0", mism);
    end
  endtask

  initial begin
    reset = 1'b0; mem_clear = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 32'h0;
    repeat (3) @(negedge clock);
    test_reset;
    test_word_store_load;
    test_byte_merge;
    test_extension;
    test_errors;
    test_reset_in_write;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
